// File: rtl/fifo_port_sched_if.sv
// fifo_port_sched_if: client request/ack bus plus the strobe interface to the shared FIFO.
// The slave modport is the scheduler; the master modport is the surrounding clients and FIFO.
interface fifo_port_sched_if #(
   parameter int RAM_SIZE      = 256,
   parameter int ADDRESS_WIDTH = 8,
   parameter int WORD_SIZE     = 8
);
   logic                   wa_req;
   logic [WORD_SIZE-1:0]   wa_data;
   logic                   wa_ack;
   logic                   wb_req;
   logic [WORD_SIZE-1:0]   wb_data;
   logic                   wb_ack;
   logic                   rd_req;
   logic [WORD_SIZE-1:0]   rd_data;
   logic                   rd_ack;
   logic                   flush_req;
   logic                   flush_ack;
   logic [ADDRESS_WIDTH:0] level;
   logic [WORD_SIZE-1:0]   fifo_d;
   logic                   fifo_write;
   logic                   fifo_read;
   logic                   fifo_reset;
   logic [WORD_SIZE-1:0]   fifo_q;
   logic                   fifo_empty;
   logic                   fifo_full;

   modport slave (
      input  wa_req, wa_data, wb_req, wb_data, rd_req, flush_req, fifo_q, fifo_empty, fifo_full,
      output wa_ack, wb_ack, rd_data, rd_ack, flush_ack, level, fifo_d, fifo_write, fifo_read, fifo_reset
   );

   modport master (
      output wa_req, wa_data, wb_req, wb_data, rd_req, flush_req, fifo_q, fifo_empty, fifo_full,
      input  wa_ack, wb_ack, rd_data, rd_ack, flush_ack, level, fifo_d, fifo_write, fifo_read, fifo_reset
   );
endinterface

// File: rtl/fifo_port_sched.sv
// fifo_port_sched: round-robin scheduler of two writers and one reader onto an edge-strobed FIFO.
// Every operation is IDLE + strobe + commit, so at most one FIFO strobe is ever active.
module fifo_port_sched #(
   parameter int RAM_SIZE      = 256,
   parameter int ADDRESS_WIDTH = 8,
   parameter int WORD_SIZE     = 8
) (
   input logic              clk,
   input logic              reset_n,
   fifo_port_sched_if.slave bus
);
   typedef enum logic [2:0] {IDLE, WSTB, WCOM, RSTB, RCOM, FLUSH} state_t;
   typedef enum logic [1:0] {CL_A, CL_B, CL_R} client_t;

   localparam logic [ADDRESS_WIDTH:0] LVL_MAX = RAM_SIZE[ADDRESS_WIDTH:0];

   state_t                 r_state;
   client_t                r_last;
   logic                   r_sel_b;
   logic                   r_wa_ack, r_wb_ack, r_rd_ack, r_flush_ack;
   logic                   r_fifo_write, r_fifo_read, r_fifo_reset;
   logic [WORD_SIZE-1:0]   r_fifo_d, r_rd_data;
   logic [ADDRESS_WIDTH:0] r_level;
   logic                   w_ea, w_eb, w_er, w_any;
   client_t                w_win;

   assign w_ea  = bus.wa_req & ~bus.fifo_full;
   assign w_eb  = bus.wb_req & ~bus.fifo_full;
   assign w_er  = bus.rd_req & ~bus.fifo_empty;
   assign w_any = w_ea | w_eb | w_er;

   // search starts at the client after the last grant, cycling A -> B -> R
   always_comb begin
      w_win = r_last == CL_R ? (w_ea ? CL_A : w_eb ? CL_B : CL_R)
            : r_last == CL_A ? (w_eb ? CL_B : w_er ? CL_R : CL_A)
            :                  (w_er ? CL_R : w_ea ? CL_A : CL_B);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state      <= FLUSH;
         r_last       <= CL_R;
         r_sel_b      <= 1'b0;
         r_wa_ack     <= 1'b0;
         r_wb_ack     <= 1'b0;
         r_rd_ack     <= 1'b0;
         r_flush_ack  <= 1'b0;
         r_fifo_write <= 1'b0;
         r_fifo_read  <= 1'b0;
         r_fifo_reset <= 1'b1;
         r_fifo_d     <= '0;
         r_rd_data    <= '0;
         r_level      <= '0;
      end else begin
         r_wa_ack     <= 1'b0;
         r_wb_ack     <= 1'b0;
         r_rd_ack     <= 1'b0;
         r_flush_ack  <= 1'b0;
         r_fifo_write <= 1'b0;
         r_fifo_read  <= 1'b0;
         r_fifo_reset <= 1'b0;
         case (r_state)
            IDLE: begin
               if (bus.flush_req) begin
                  r_state      <= FLUSH;
                  r_fifo_reset <= 1'b1;
                  r_flush_ack  <= 1'b1;
                  r_level      <= '0;
               end else if (w_any) begin
                  r_last <= w_win;
                  if (w_win == CL_R) begin
                     r_state     <= RSTB;
                     r_fifo_read <= 1'b1;
                  end else begin
                     r_state      <= WSTB;
                     r_fifo_write <= 1'b1;
                     r_sel_b      <= w_win == CL_B;
                     r_fifo_d     <= w_win == CL_B ? bus.wb_data : bus.wa_data;
                  end
               end
            end
            WSTB: begin
               r_state  <= WCOM;
               r_wa_ack <= ~r_sel_b;
               r_wb_ack <= r_sel_b;
               if (r_level != LVL_MAX) r_level <= r_level + 1'b1;
            end
            RSTB: begin
               r_state   <= RCOM;
               r_rd_ack  <= 1'b1;
               r_rd_data <= bus.fifo_q;
               if (r_level != '0) r_level <= r_level - 1'b1;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign bus.wa_ack     = r_wa_ack;
   assign bus.wb_ack     = r_wb_ack;
   assign bus.rd_ack     = r_rd_ack;
   assign bus.flush_ack  = r_flush_ack;
   assign bus.rd_data    = r_rd_data;
   assign bus.level      = r_level;
   assign bus.fifo_d     = r_fifo_d;
   assign bus.fifo_write = r_fifo_write;
   assign bus.fifo_read  = r_fifo_read;
   assign bus.fifo_reset = r_fifo_reset;
endmodule

// File: tb/tb_fifo_port_sched.sv
// tb_fifo_port_sched: directed client traffic against a behavioural edge-strobed FIFO,
// with an ack scoreboard checked by an independent monitor.
module tb_fifo_port_sched;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   fifo_port_sched_if bus ();
   fifo_port_sched dut (.clk(clk), .reset_n(reset_n), .bus(bus));

   logic [7:0] q[$];
   logic       pw = 1'b0, pr = 1'b0;
   logic [7:0] f_q = 8'h00;
   logic       f_empty = 1'b1, f_full = 1'b0;
   assign bus.fifo_q     = f_q;
   assign bus.fifo_empty = f_empty;
   assign bus.fifo_full  = f_full;

   // FIFO commits/pops on the falling edge of its strobe, seen here one clock later
   always @(posedge clk) begin
      if (bus.fifo_reset) q.delete();
      else begin
         if (pw && !bus.fifo_write) q.push_back(bus.fifo_d);
         if (pr && !bus.fifo_read && q.size() > 0) void'(q.pop_front());
      end
      pw      <= bus.fifo_write;
      pr      <= bus.fifo_read;
      f_q     <= q.size() > 0 ? q[0] : 8'h00;
      f_empty <= q.size() == 0;
      f_full  <= q.size() >= 256;
   end

   typedef struct {int kind; logic [7:0] data; int lvl; bit gap3;} exp_t;
   exp_t exq[$];
   int   checks = 0, errors = 0, cyc = 0, last_ack = 0, n_wr = 0, n_rd = 0;
   logic pw_m = 1'b0, pr_m = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin : mon
      exp_t       e;
      logic [3:0] acks;
      if (reset_n) begin
         acks = {bus.flush_ack, bus.rd_ack, bus.wb_ack, bus.wa_ack};
         checks++;
         if ($countones({bus.fifo_write, bus.fifo_read, bus.fifo_reset}) > 1) begin
            errors++;
            $display("FAIL strobe_exclusive got w=%b r=%b rst=%b expected at most one high",
                     bus.fifo_write, bus.fifo_read, bus.fifo_reset);
         end
         if (bus.fifo_write && !pw_m) n_wr++;
         if (bus.fifo_read && !pr_m) n_rd++;
         pw_m = bus.fifo_write;
         pr_m = bus.fifo_read;
         if (acks != 4'b0) begin
            checks++;
            if (exq.size() == 0) begin
               errors++;
               $display("FAIL unexpected_ack got ack=%b expected no ack", acks);
            end else begin
               e = exq.pop_front();
               if (acks != 4'(1 << e.kind) || int'(bus.level) != e.lvl ||
                   (e.kind == 2 && bus.rd_data != e.data) || (e.gap3 && cyc - last_ack != 3)) begin
                  errors++;
                  $display("FAIL ack_kind%0d got ack=%b level=%0d rd_data=%h gap=%0d expected ack=%b level=%0d rd_data=%h gap3=%0d",
                           e.kind, acks, bus.level, bus.rd_data, cyc - last_ack,
                           4'(1 << e.kind), e.lvl, e.data, e.gap3);
               end
            end
            last_ack = cyc;
         end
      end
   end

   task automatic chk(input string nm, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", nm, got, exp);
      end
   endtask

   task automatic push(input int k, input logic [7:0] d, input int l, input bit g);
      exq.push_back('{k, d, l, g});
   endtask

   function automatic logic ack_of(input int k);
      return k == 0 ? bus.wa_ack : k == 1 ? bus.wb_ack : k == 2 ? bus.rd_ack : bus.flush_ack;
   endfunction

   task automatic wait_ack(input int k);
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ack_of(k) && n < 2000);
      if (!ack_of(k)) begin
         errors++;
         $display("FAIL ack_wait kind%0d got no ack expected ack within 2000 cycles", k);
      end
   endtask

   task automatic do_w(input bit b, input int n, input logic [7:0] d0, input logic [7:0] st);
      for (int i = 0; i < n; i++) begin
         if (b) begin
            bus.wb_data = d0 + 8'(i * int'(st));
            bus.wb_req  = 1'b1;
         end else begin
            bus.wa_data = d0 + 8'(i * int'(st));
            bus.wa_req  = 1'b1;
         end
         wait_ack(b ? 1 : 0);
      end
      if (b) bus.wb_req = 1'b0;
      else bus.wa_req = 1'b0;
   endtask

   task automatic do_rd(input int n);
      bus.rd_req = 1'b1;
      for (int i = 0; i < n; i++) wait_ack(2);
      bus.rd_req = 1'b0;
   endtask

   task automatic do_flush();
      bus.flush_req = 1'b1;
      wait_ack(3);
      bus.flush_req = 1'b0;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog got timeout expected bench completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int rel, wr0, rd0;
      bus.wa_req = 1'b1; bus.wa_data = 8'hA1;
      bus.wb_req = 1'b0; bus.wb_data = 8'h00;
      bus.rd_req = 1'b0; bus.flush_req = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_fifo_reset", int'(bus.fifo_reset), 1);
      chk("rst_level", int'(bus.level), 0);
      chk("rst_acks", int'({bus.wa_ack, bus.wb_ack, bus.rd_ack, bus.flush_ack}), 0);
      chk("rst_strobes", int'({bus.fifo_write, bus.fifo_read}), 0);
      chk("rst_fifo_d", int'(bus.fifo_d), 0);
      chk("rst_rd_data", int'(bus.rd_data), 0);
      push(0, 8'h00, 1, 1'b0);
      reset_n = 1'b1;
      rel = cyc;
      #1 chk("release_flush_cycle", int'(bus.fifo_reset), 1);
      do_w(1'b0, 1, 8'hA1, 8'h00);
      chk("release_ack_cycle", cyc - rel, 3);

      push(1, 8'h00, 2, 1'b0); do_w(1'b1, 1, 8'hB2, 8'h00);
      push(0, 8'h00, 3, 1'b0); do_w(1'b0, 1, 8'hA3, 8'h00);
      push(2, 8'hA1, 2, 1'b0); do_rd(1);

      // all three held: expect A, B, R, A
      push(0, 8'h00, 3, 1'b0); push(1, 8'h00, 4, 1'b1);
      push(2, 8'hB2, 3, 1'b1); push(0, 8'h00, 4, 1'b1);
      fork
         do_w(1'b0, 2, 8'hC1, 8'h02);
         do_w(1'b1, 1, 8'hC2, 8'h00);
         do_rd(1);
      join
      chk("rr_level", int'(bus.level), 4);

      for (int i = 0; i < 252; i++) push(0, 8'h00, 5 + i, i > 0);
      do_w(1'b0, 252, 8'h10, 8'h01);
      chk("full_level", int'(bus.level), 256);
      wr0 = n_wr; rd0 = n_rd;
      fork
         do_w(1'b0, 1, 8'hEE, 8'h00);
         begin
            repeat (20) @(negedge clk);
            chk("full_no_write", n_wr - wr0, 0);
            chk("full_level_held", int'(bus.level), 256);
            push(2, 8'hA3, 255, 1'b0); push(0, 8'h00, 256, 1'b1);
            do_rd(1);
         end
      join
      chk("full_one_read", n_rd - rd0, 1);
      chk("full_one_write", n_wr - wr0, 1);

      push(3, 8'h00, 0, 1'b0); do_flush();
      wr0 = n_wr; rd0 = n_rd;
      fork
         do_rd(1);
         begin
            repeat (15) @(negedge clk);
            chk("empty_no_read", n_rd - rd0, 0);
            push(1, 8'h00, 1, 1'b0); push(2, 8'h5A, 0, 1'b1);
            do_w(1'b1, 1, 8'h5A, 8'h00);
         end
      join
      chk("empty_one_read", n_rd - rd0, 1);

      push(0, 8'h00, 1, 1'b0); do_w(1'b0, 1, 8'h11, 8'h00);
      push(1, 8'h00, 2, 1'b0); do_w(1'b1, 1, 8'h22, 8'h00);
      push(2, 8'h11, 1, 1'b0); push(2, 8'h22, 0, 1'b1); do_rd(2);
      repeat (5) @(negedge clk);
      chk("order_rd_data_held", int'(bus.rd_data), 8'h22);

      for (int i = 0; i < 5; i++) push(0, 8'h00, 1 + i, i > 0);
      do_w(1'b0, 5, 8'h30, 8'h01);
      chk("flush_pre_level", int'(bus.level), 5);
      push(3, 8'h00, 0, 1'b0); push(0, 8'h00, 1, 1'b1);
      fork
         do_flush();
         do_w(1'b0, 1, 8'h77, 8'h00);
      join

      repeat (5) @(negedge clk);
      chk("scoreboard_drained", exq.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
